// File: rtl/upc_checkout_ctrl_pkg.sv
// rtl/upc_checkout_ctrl_pkg.sv - shared UPC classification masks and FSM state type
// Imported by the checkout controller and by the marker/display logic so both
// classify a UPC from the same mask constants.
package upc_pkg;

  // Controller states; the controller keeps its own legacy-width constants
  // derived from these values.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_ALARM = 2'd2
  } upc_state_e;

  // Bit n set: UPC n is sold at a discount.
  localparam logic [7:0] DISC_MASK = 8'b1010_0110;

  // Bit n set: UPC n is an expensive item that must carry a security mark.
  localparam logic [7:0] EXP_MASK  = 8'b1100_1000;

  function automatic logic upc_is_disc(input logic [2:0] upc);
    return DISC_MASK[upc];
  endfunction

  // An expensive item without its security mark is treated as stolen.
  function automatic logic upc_is_stolen(input logic [2:0] upc, input logic mark);
    return EXP_MASK[upc] & ~mark;
  endfunction

endpackage

// File: rtl/upc_checkout_ctrl_if.sv
// rtl/upc_checkout_ctrl_if.sv - scanner handshake and result bus of the checkout controller
// master drives scans and operator controls; slave is the controller.
interface upc_checkout_ctrl_if #(
  parameter int COUNT_W = 8
);

  logic               scan_valid;
  logic               scan_ready;
  logic [2:0]         upc;
  logic               mark;
  logic               clear_alarm;
  logic               clear_cnt;
  logic [2:0]         last_upc;
  logic               last_disc;
  logic               alarm;
  logic               result_valid;
  logic [COUNT_W-1:0] item_cnt;
  logic [COUNT_W-1:0] disc_cnt;

  modport master (
    output scan_valid, upc, mark, clear_alarm, clear_cnt,
    input  scan_ready, last_upc, last_disc, alarm, result_valid, item_cnt, disc_cnt
  );

  modport slave (
    input  scan_valid, upc, mark, clear_alarm, clear_cnt,
    output scan_ready, last_upc, last_disc, alarm, result_valid, item_cnt, disc_cnt
  );

endinterface

// File: rtl/upc_checkout_ctrl_sat_counter.sv
// rtl/upc_checkout_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
// Clear has priority over increment; the count sticks at all-ones.
module upc_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_full;

  assign w_full = &r_cnt;
  assign o_cnt  = r_cnt;

  // Count up on i_inc until all-ones; i_clr zeroes regardless of i_inc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_full) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/upc_checkout_ctrl.sv
// rtl/upc_checkout_ctrl.sv - scan/evaluate/alarm sequencer for the UPC checkout datapath
// Optional feature: define UPC_ALARM_TIMEOUT_EN to auto-clear the alarm after ALARM_CYCLES clocks.
module upc_checkout_ctrl
  import upc_pkg::*;
#(
  parameter int COUNT_W      = 8,
  parameter int ALARM_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  upc_checkout_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_EVAL  = 2'(ST_EVAL);
  localparam logic [1:0] S_ALARM = 2'(ST_ALARM);

  logic [1:0]         r_state;
  logic [2:0]         r_upc;
  logic               r_mark;
  logic [2:0]         r_last_upc;
  logic               r_last_disc;
  logic               r_alarm;
  logic               r_result_valid;

  logic               w_idle;
  logic               w_eval;
  logic               w_in_alarm;
  logic               w_disc;
  logic               w_stolen;
  logic               w_inc_item;
  logic               w_inc_disc;
  logic               w_timeout;
  logic               w_alarm_exit;
  logic [COUNT_W-1:0] w_item_cnt;
  logic [COUNT_W-1:0] w_disc_cnt;

  assign w_idle     = (r_state == S_IDLE);
  assign w_eval     = (r_state == S_EVAL);
  assign w_in_alarm = (r_state == S_ALARM);

  // Classification always uses the latched item, never the live scanner inputs.
  assign w_disc     = upc_is_disc(r_upc);
  assign w_stolen   = upc_is_stolen(r_upc, r_mark);

  // Stolen items are never counted.
  assign w_inc_item = w_eval && !w_stolen;
  assign w_inc_disc = w_inc_item && w_disc;

`ifdef UPC_ALARM_TIMEOUT_EN
  localparam int         TW    = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(ALARM_CYCLES - 1);

  logic [TW-1:0] r_timer;

  // Load on the edge that enters ALARM, then count down to zero; the alarm
  // is released on the edge where the timer already reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_eval && w_stolen) begin
      r_timer <= TLOAD;
    end else if (w_in_alarm && (r_timer != '0)) begin
      r_timer <= r_timer - 1'b1;
    end
  end

  assign w_timeout = w_in_alarm && (r_timer == '0);
`else
  // No timer in this build: ALARM_CYCLES has no effect and this is constant 0.
  assign w_timeout = (ALARM_CYCLES < 0);
`endif

  assign w_alarm_exit = w_in_alarm && (bus.clear_alarm || w_timeout);

  // Main sequencer: accept in IDLE, classify in EVAL, hold in ALARM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_upc       <= '0;
      r_mark      <= 1'b0;
      r_last_upc  <= '0;
      r_last_disc <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.scan_valid) begin
            r_upc   <= bus.upc;
            r_mark  <= bus.mark;
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_last_upc  <= r_upc;
          r_last_disc <= w_disc;
          if (w_stolen) begin
            r_alarm <= 1'b1;
            r_state <= S_ALARM;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ALARM: begin
          if (w_alarm_exit) begin
            r_alarm <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // One-cycle pulse in the cycle after EVAL, aligned with the last_* update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= w_eval;
    end
  end

  upc_sat_counter #(
    .W (COUNT_W)
  ) u_item_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_inc_item),
    .i_clr (bus.clear_cnt),
    .o_cnt (w_item_cnt)
  );

  upc_sat_counter #(
    .W (COUNT_W)
  ) u_disc_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_inc_disc),
    .i_clr (bus.clear_cnt),
    .o_cnt (w_disc_cnt)
  );

  assign bus.scan_ready   = w_idle;
  assign bus.last_upc     = r_last_upc;
  assign bus.last_disc    = r_last_disc;
  assign bus.alarm        = r_alarm;
  assign bus.result_valid = r_result_valid;
  assign bus.item_cnt     = w_item_cnt;
  assign bus.disc_cnt     = w_disc_cnt;

endmodule

// File: tb/tb_upc_checkout_ctrl.sv
// tb/tb_upc_checkout_ctrl.sv - directed plus randomized self-checking bench for upc_checkout_ctrl
module tb_upc_checkout_ctrl;

  localparam int CW   = 3;
  localparam int MAXC = 7;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  upc_checkout_ctrl_if #(.COUNT_W(CW)) bus ();

  upc_checkout_ctrl #(
    .COUNT_W      (CW),
    .ALARM_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int exp_item = 0;
  int exp_disc = 0;

  // Item classification table, index = UPC.
  bit disc_tab [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  bit exp_tab  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int sat_inc(input int c);
    return (c < MAXC) ? c + 1 : c;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_item"}, 32'(bus.item_cnt), exp_item);
    check({tag, "_disc"}, 32'(bus.disc_cnt), exp_disc);
  endtask

  // Present one item, follow it through EVAL, check the result cycle.
  task automatic run_item(input logic [2:0] u, input logic m, input bit clr, output bit stolen);
    int w;
    w = 0;
    while (bus.scan_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_scan", 32'(bus.scan_ready), 1);
    bus.scan_valid = 1'b1;
    bus.upc        = u;
    bus.mark       = m;
    @(negedge clk);
    bus.scan_valid = 1'b0;
    bus.upc        = 3'($urandom);
    bus.mark       = 1'($urandom);
    bus.clear_cnt  = clr;
    check("eval_ready_low", 32'(bus.scan_ready), 0);
    check("eval_no_result", 32'(bus.result_valid), 0);
    @(negedge clk);
    bus.clear_cnt = 1'b0;
    stolen = exp_tab[u] && !m;
    if (clr) begin
      exp_item = 0;
      exp_disc = 0;
    end else if (!stolen) begin
      exp_item = sat_inc(exp_item);
      if (disc_tab[u]) exp_disc = sat_inc(exp_disc);
    end
    check("result_valid", 32'(bus.result_valid), 1);
    check("last_upc", 32'(bus.last_upc), 32'(u));
    check("last_disc", 32'(bus.last_disc), 32'(disc_tab[u]));
    check("alarm_after_eval", 32'(bus.alarm), 32'(stolen));
    check("ready_after_eval", 32'(bus.scan_ready), 32'(!stolen));
    check_counts("cnt_after_eval");
  endtask

  task automatic clear_alarm_seq();
    bus.clear_alarm = 1'b1;
    @(negedge clk);
    bus.clear_alarm = 1'b0;
    check("alarm_cleared", 32'(bus.alarm), 0);
    check("ready_after_clear", 32'(bus.scan_ready), 1);
  endtask

  initial begin
    bit s;
    int hi;
    bus.scan_valid  = 1'b0;
    bus.upc         = 3'd0;
    bus.mark        = 1'b0;
    bus.clear_alarm = 1'b0;
    bus.clear_cnt   = 1'b0;
    reset           = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.scan_ready), 1);
    check("rst_alarm", 32'(bus.alarm), 0);
    check("rst_rv", 32'(bus.result_valid), 0);
    check("rst_last_upc", 32'(bus.last_upc), 0);
    check("rst_last_disc", 32'(bus.last_disc), 0);
    check_counts("rst");

    // Marked discounted item.
    run_item(3'd1, 1'b1, 1'b0, s);
    @(negedge clk);
    check("rv_one_cycle", 32'(bus.result_valid), 0);

    // Reset one cycle after accepting a discounted item.
    bus.scan_valid = 1'b1;
    bus.upc        = 3'd2;
    bus.mark       = 1'b1;
    @(negedge clk);
    bus.scan_valid = 1'b0;
    reset          = 1'b1;
    exp_item       = 0;
    exp_disc       = 0;
    @(negedge clk);
    check("rstmid_alarm", 32'(bus.alarm), 0);
    check("rstmid_rv", 32'(bus.result_valid), 0);
    check("rstmid_last_upc", 32'(bus.last_upc), 0);
    check("rstmid_last_disc", 32'(bus.last_disc), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_ready", 32'(bus.scan_ready), 1);
    check("rstmid_rv_after", 32'(bus.result_valid), 0);
    check_counts("rstmid");

    // Build some count, then a stolen item.
    run_item(3'd5, 1'b1, 1'b0, s);
    run_item(3'd3, 1'b0, 1'b0, s);
    bus.scan_valid = 1'b1;
    bus.upc        = 3'd1;
    bus.mark       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("alarm_held", 32'(bus.alarm), 1);
      check("alarm_not_ready", 32'(bus.scan_ready), 0);
      check("alarm_no_result", 32'(bus.result_valid), 0);
    end
    bus.scan_valid = 1'b0;
    check_counts("alarm_cnt");
    bus.clear_cnt = 1'b1;
    @(negedge clk);
    bus.clear_cnt = 1'b0;
    exp_item = 0;
    exp_disc = 0;
    check_counts("clr_in_alarm");
    check("alarm_after_clrcnt", 32'(bus.alarm), 1);
    clear_alarm_seq();

    // Saturation with non-discounted marked items.
    for (int i = 0; i < 9; i++) begin
      run_item(($urandom_range(0, 1) == 0) ? 3'd0 : 3'd4, 1'b1, 1'b0, s);
    end
    check("sat_item_held", 32'(bus.item_cnt), 7);

    // Clear coinciding with an EVAL increment.
    run_item(3'd5, 1'b1, 1'b1, s);
    check("clr_eval_item", 32'(bus.item_cnt), 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] u;
      logic       m;
      bit         c;
      u = 3'($urandom_range(0, 7));
      m = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 7) == 0);
      run_item(u, m, c, s);
      if (s) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("rand_alarm_held", 32'(bus.alarm), 1);
        clear_alarm_seq();
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Alarm with no operator acknowledge.
    run_item(3'd6, 1'b0, 1'b0, s);
`ifdef UPC_ALARM_TIMEOUT_EN
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.alarm !== 1'b1) break;
      hi++;
    end
    check("timeout_cycles", 32'(hi), 16);
    check("timeout_ready", 32'(bus.scan_ready), 1);
`else
    hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.alarm === 1'b1) hi++;
    end
    check("no_timeout_alarm", 32'(hi), 100);
    clear_alarm_seq();
`endif
    check_counts("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/upc_checkout_ctrl.md
# upc_checkout_ctrl

Sequencing controller for the UPC checkout datapath. It accepts scanned items (3-bit UPC plus security mark) from a scanner front end over a valid/ready handshake and classifies each item as discounted or stolen. It keeps running item and discount counts and holds a stolen-item alarm until an operator clears it. It sits between the switch/scanner inputs and the marker/hex display logic on the DE1-SoC top level, and feeds them a stable latched UPC.

## Interface
Parameters:
- COUNT_W, 8: width of the item and discount counters.
- ALARM_CYCLES, 16: alarm auto-clear timeout in clocks; used only with the timeout feature compiled in (see Configuration).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- scan_valid  input  1  scanner presents an item.
- scan_ready  output  1  controller can accept an item.
- upc  input  3  UPC code of the presented item.
- mark  input  1  security mark present on the item.
- clear_alarm  input  1  operator acknowledge; synchronous, level-sampled.
- clear_cnt  input  1  synchronous clear of both counters.
- last_upc  output  3  UPC of the most recently evaluated item, for the hex display.
- last_disc  output  1  most recent item was discounted.
- alarm  output  1  stolen-item alarm is active.
- result_valid  output  1  one-cycle pulse when the last_* outputs update.
- item_cnt  output  COUNT_W  number of accepted non-stolen items.
- disc_cnt  output  COUNT_W  number of accepted discounted items.

## Operation
- FSM states: IDLE, EVAL, ALARM.
- IDLE:
  - scan_ready=1.
  - When scan_valid && scan_ready at a clock edge: latch upc and mark into internal registers, then go to EVAL.
- EVAL:
  - scan_ready=0. Classify the latched item using the package masks:
    - disc = DISC_MASK[upc]
    - stolen = EXP_MASK[upc] && !mark
  - At the end of EVAL:
    - last_upc ← latched upc; last_disc ← disc; result_valid=1 for the following cycle.
    - If stolen: alarm ← 1, no counter change, go to ALARM.
    - Otherwise: item_cnt += 1; disc_cnt += disc; go to IDLE.
- ALARM:
  - scan_ready=0; alarm=1.
  - clear_alarm=1 at an edge → alarm ← 0 and go to IDLE.
  - clear_alarm in IDLE or EVAL is ignored.
- Counters saturate at 2^COUNT_W−1 and never wrap.
- clear_cnt zeroes both counters at the next edge, in any state.
  - If clear_cnt coincides with an EVAL increment, the clear wins: counters read 0.
- A stolen item never increments item_cnt or disc_cnt.
- Reset (asynchronous, valid mid-operation):
  - state=IDLE, scan_ready=1 once reset deasserts.
  - last_upc=0, last_disc=0, alarm=0, result_valid=0, item_cnt=0, disc_cnt=0.
  - Any item latched but not yet evaluated is dropped.

## Timing
- Acceptance at edge N.
- At edge N+1: last_upc, last_disc, alarm and the counters update; result_valid is high for the cycle from N+1 to N+2.
- scan_ready is low in the cycle after acceptance, so throughput is at most one item per 2 clocks.
- After a non-stolen item, the earliest next acceptance is edge N+2.
- The upc and mark inputs need only be stable at the acceptance edge.
- clear_alarm takes effect at the sampling edge; scan_ready is high in the following cycle.

## Configuration
- UPC_ALARM_TIMEOUT_EN defined:
  - On entering ALARM, a timer loads ALARM_CYCLES−1 and decrements each clock.
  - At zero, the controller clears alarm and returns to IDLE on that edge, exactly ALARM_CYCLES clocks after entry.
  - clear_alarm still clears early.
  - Timer width is $clog2(ALARM_CYCLES).
- Undefined: no timer logic; ALARM is left only via clear_alarm or reset.

## Structure
- Package upc_pkg holds:
  - the state enum typedef;
  - the constant 8-bit DISC_MASK and EXP_MASK lookup vectors, indexed by UPC.
- The combinational marker and display logic also imports upc_pkg so both paths use the same masks.
- One sub-module: upc_sat_counter (parameterised width, inc, clr, saturating). It is instantiated twice.

## Test plan
- Reset mid-EVAL:
  - Stimulus: assert reset one cycle after accepting a discounted UPC.
  - Required: all outputs 0, scan_ready=1 after deassert, counters 0.
- Marked discounted item:
  - Stimulus: upc with DISC_MASK=1 and EXP_MASK=0, mark=1.
  - Required: result_valid pulse at N+1, last_upc matches, last_disc=1, item_cnt=1, disc_cnt=1, scan_ready=0 in cycle N+1.
- Stolen item:
  - Stimulus: upc with EXP_MASK=1, mark=0.
  - Required: alarm=1, counters unchanged.
  - A further scan_valid held 5 cycles is not accepted.
  - clear_alarm → alarm=0, scan_ready=1 next cycle.
- Saturation:
  - Stimulus: COUNT_W=3, 9 non-discounted marked items.
  - Required: item_cnt=7 and held.
- clear_cnt during EVAL:
  - Stimulus: clear_cnt asserted in the same cycle as an EVAL increment.
  - Required: both counters 0.
- Timeout (UPC_ALARM_TIMEOUT_EN, ALARM_CYCLES=16):
  - Stimulus: stolen item, no clear_alarm.
  - Required: alarm drops exactly 16 clocks after rising; without the macro, alarm is still high after 100 clocks.
